// File: rtl/sd_fir_pkg.sv
// Shared definitions for the sigma-delta decimating FIR: coefficient table,
// controller states and the saturating narrow helper.
package sd_fir_pkg;

    localparam int PKG_TAPS   = 16;
    localparam int PKG_COEF_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } state_e;

    // Symmetric low-pass in Q1.15; taps sum to 32768 so DC gain is exactly one.
    localparam logic signed [PKG_COEF_W-1:0] COEFS [PKG_TAPS] = '{
        -16'sd256, -16'sd512,  16'sd0,    16'sd1024,
         16'sd2048, 16'sd3584, 16'sd4608, 16'sd5888,
         16'sd5888, 16'sd4608, 16'sd3584, 16'sd2048,
         16'sd1024, 16'sd0,   -16'sd512, -16'sd256
    };

    function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] v,
                                                      input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/sigma_delta_fir_decim_if.sv
// Sample-in / sample-out handshake bundle of the decimating FIR.
interface sigma_delta_fir_decim_if #(
    parameter int WDTH  = 16,
    parameter int OUT_W = 16
);
    logic [WDTH-1:0]         in_data;
    logic                    in_valid;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output out_data, out_valid
    );
endinterface

// File: rtl/sd_fir_ring.sv
// TAPS-deep sample history; rel_i = 0 reads the newest sample, rel_i = i reads x[n-i].
module sd_fir_ring #(
    parameter int XW   = 17,
    parameter int TAPS = 16,
    parameter int AW   = (TAPS > 1) ? $clog2(TAPS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we_i,
    input  logic signed [XW-1:0] wdata_i,
    input  logic [AW-1:0]        rel_i,
    output logic signed [XW-1:0] rdata_o
);
    logic signed [XW-1:0] mem_q [TAPS];
    logic [AW-1:0]        wptr_q;
    logic [AW-1:0]        raddr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= '0;
        end else if (we_i) begin
            mem_q[wptr_q] <= wdata_i;
            wptr_q        <= (wptr_q == AW'(TAPS - 1)) ? '0 : wptr_q + AW'(1);
        end
    end

    // wptr_q points one past the newest entry; fold negative offsets back modulo TAPS.
    always_comb begin
        int a;
        a = int'(wptr_q) - 1 - int'(rel_i);
        if (a < 0) begin
            a = a + TAPS;
        end
        raddr = AW'(a);
    end

    assign rdata_o = mem_q[raddr];

endmodule

// File: rtl/sigma_delta_fir_decim.sv
// Offset removal, shared-multiplier FIR and decimation by DECIM for the sigma-delta front end.
// Build macro SD_FIR_BYPASS_EN adds a bypass input that sends saturated raw samples straight out.
module sigma_delta_fir_decim
    import sd_fir_pkg::*;
#(
    parameter int WDTH      = 16,
    parameter int OUT_W     = 16,
    parameter int TAPS      = 16,
    parameter int COEF_W    = 16,
    parameter int DECIM     = 2,
    parameter int IN_OFFSET = 128
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sigma_delta_fir_decim_if.slave bus,
`ifdef SD_FIR_BYPASS_EN
    input  logic                   bypass,
`endif
    output logic                   busy,
    output logic                   overrun
);
    localparam int XW    = WDTH + 1;
    localparam int PW    = XW + COEF_W;
    localparam int ACC_W = PW + $clog2(TAPS);
    localparam int TW    = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int CW    = (DECIM > 1) ? $clog2(DECIM) : 1;

    state_e                  state_q, state_d;
    logic [TW-1:0]           tap_q, tap_d;
    logic [CW-1:0]           dcnt_q, dcnt_d;
    logic signed [OUT_W-1:0] out_data_q, out_data_d;
    logic                    overrun_q, overrun_d;
    logic                    vld_p1_q;
    logic signed [PW-1:0]    prod_p1_q;
    logic signed [ACC_W-1:0] acc_q, acc_d;

    logic signed [XW-1:0]     x_s;
    logic signed [XW-1:0]     tap_x;
    logic signed [COEF_W-1:0] coef_s;
    logic signed [PW-1:0]     prod_s;
    logic                     accept;
    logic                     trigger;
    logic                     byp;
    logic                     start;

    function automatic logic signed [OUT_W-1:0] round_sat(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] r;
        r = (a + (ACC_W'(1) <<< (COEF_W - 2))) >>> (COEF_W - 1);
        return OUT_W'(sat_narrow(64'(r), OUT_W));
    endfunction

`ifdef SD_FIR_BYPASS_EN
    assign byp = bypass;
`else
    assign byp = 1'b0;
`endif

    assign x_s     = $signed({1'b0, bus.in_data}) - XW'(IN_OFFSET);
    assign accept  = bus.in_valid && ((state_q == IDLE) || ((state_q == OUT) && bus.out_ready));
    assign trigger = accept && (dcnt_q == CW'(DECIM - 1));

    sd_fir_ring #(
        .XW   (XW),
        .TAPS (TAPS),
        .AW   (TW)
    ) u_ring (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (accept),
        .wdata_i (x_s),
        .rel_i   (tap_q),
        .rdata_o (tap_x)
    );

    // Stage p0: one tap product per MAC cycle, registered into p1.
    assign coef_s = COEF_W'(COEFS[tap_q]);
    assign prod_s = PW'(tap_x) * PW'(coef_s);

    always_comb begin
        state_d    = state_q;
        tap_d      = tap_q;
        dcnt_d     = dcnt_q;
        out_data_d = out_data_q;
        overrun_d  = overrun_q;
        acc_d      = acc_q;
        start      = 1'b0;

        if (bus.in_valid && !accept) begin
            overrun_d = 1'b1;
        end
        if (accept) begin
            dcnt_d = (dcnt_q == CW'(DECIM - 1)) ? '0 : dcnt_q + CW'(1);
        end
        // Stage p1 -> accumulator.
        if (vld_p1_q) begin
            acc_d = acc_q + ACC_W'(prod_p1_q);
        end

        case (state_q)
            IDLE: begin
                start = trigger;
            end
            MAC: begin
                tap_d = tap_q + TW'(1);
                if (tap_q == TW'(TAPS - 1)) begin
                    tap_d   = '0;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                // Wait one cycle for the last product to drain into the accumulator.
                if (!vld_p1_q) begin
                    out_data_d = round_sat(acc_q);
                    state_d    = OUT;
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    start   = trigger;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            if (byp) begin
                out_data_d = OUT_W'(sat_narrow(64'(x_s), OUT_W));
                state_d    = OUT;
            end else begin
                state_d = MAC;
                tap_d   = '0;
                acc_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tap_q      <= '0;
            dcnt_q     <= '0;
            out_data_q <= '0;
            overrun_q  <= 1'b0;
            vld_p1_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tap_q      <= tap_d;
            dcnt_q     <= dcnt_d;
            out_data_q <= out_data_d;
            overrun_q  <= overrun_d;
            vld_p1_q   <= (state_q == MAC);
        end
    end

    always_ff @(posedge clk) begin
        prod_p1_q <= prod_s;
        acc_q     <= acc_d;
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = (state_q == OUT);
    assign busy          = (state_q != IDLE);
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_sigma_delta_fir_decim.sv
// Scoreboard bench for sigma_delta_fir_decim: a DECIM=2 instance plus a DECIM=1 instance.
module tb_sigma_delta_fir_decim;

    logic clk = 1'b0;
    logic rst_n;
    logic busy0, ovr0, busy1, ovr1;

    always #5 clk = ~clk;

    sigma_delta_fir_decim_if #(.WDTH(16), .OUT_W(16)) bus0 ();
    sigma_delta_fir_decim_if #(.WDTH(16), .OUT_W(16)) bus1 ();

    sigma_delta_fir_decim #(
        .WDTH(16), .OUT_W(16), .TAPS(16), .COEF_W(16), .DECIM(2), .IN_OFFSET(128)
    ) u_dut0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus0),
`ifdef SD_FIR_BYPASS_EN
        .bypass  (1'b0),
`endif
        .busy    (busy0),
        .overrun (ovr0)
    );

    sigma_delta_fir_decim #(
        .WDTH(16), .OUT_W(16), .TAPS(16), .COEF_W(16), .DECIM(1), .IN_OFFSET(128)
    ) u_dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus1),
`ifdef SD_FIR_BYPASS_EN
        .bypass  (1'b0),
`endif
        .busy    (busy1),
        .overrun (ovr1)
    );

    int coef_tb [16] = '{-256, -512, 0, 1024, 2048, 3584, 4608, 5888,
                         5888, 4608, 3584, 2048, 1024, 0, -512, -256};

    int h0 [16];
    int h1 [16];
    int dc0;
    int run0;
    int last0;
    int q0 [$];
    int q1 [$];
    int n_checks = 0;
    int n_pass   = 0;

    function automatic int fir_model(input int h [16]);
        longint acc;
        acc = 0;
        for (int i = 0; i < 16; i++) begin
            acc += longint'(coef_tb[i]) * longint'(h[i]);
        end
        acc = (acc + 64'sd16384) >>> 15;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        return int'(acc);
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            h0[i] = 0;
            h1[i] = 0;
        end
        dc0  = 0;
        run0 = 0;
    endtask

    // One accepted strobe; pushes the expected output when it triggers.
    task automatic send(input int which, input int d, input int gap,
                        input bit hand_en, input int hand_val);
        int x;
        int e;
        bit trig;
        x = d - 128;
        @(posedge clk); #1;
        if (which == 0) begin
            bus0.in_data  = 16'(d);
            bus0.in_valid = 1'b1;
        end else begin
            bus1.in_data  = 16'(d);
            bus1.in_valid = 1'b1;
        end
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        bus1.in_valid = 1'b0;
        if (which == 0) begin
            for (int i = 15; i > 0; i--) h0[i] = h0[i-1];
            h0[0] = x;
            run0  = (h0[0] == h0[1]) ? run0 + 1 : 1;
            trig  = (dc0 == 1);
            dc0   = trig ? 0 : dc0 + 1;
            if (trig) begin
                e = (hand_en && run0 >= 16) ? hand_val : fir_model(h0);
                q0.push_back(e);
                last0 = e;
            end
        end else begin
            for (int i = 15; i > 0; i--) h1[i] = h1[i-1];
            h1[0] = x;
            q1.push_back(fir_model(h1));
        end
        repeat (gap) @(posedge clk);
    endtask

    task automatic measure(input int which, output int cyc, output bit busy_ok);
        bit seen;
        cyc     = -1;
        busy_ok = 1'b1;
        seen    = 1'b0;
        for (int j = 1; j <= 40 && !seen; j++) begin
            @(posedge clk); #1;
            if ((which == 0) ? bus0.out_valid : bus1.out_valid) begin
                cyc  = j;
                seen = 1'b1;
            end else if (!((which == 0) ? busy0 : busy1)) begin
                busy_ok = 1'b0;
            end
        end
    endtask

    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (rst_n && bus0.out_valid && bus0.out_ready) begin
                if (q0.size() == 0) begin
                    n_checks++;
                    $display("FAIL out0_unexpected: got %0d, required no output", bus0.out_data);
                end else begin
                    e = q0.pop_front();
                    check("out0_data", longint'(bus0.out_data), longint'(e));
                end
            end
        end
    end

    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (rst_n && bus1.out_valid && bus1.out_ready) begin
                if (q1.size() == 0) begin
                    n_checks++;
                    $display("FAIL out1_unexpected: got %0d, required no output", bus1.out_data);
                end else begin
                    e = q1.pop_front();
                    check("out1_data", longint'(bus1.out_data), longint'(e));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        bit  bok;
        bus0.in_data = '0; bus0.in_valid = 1'b0; bus0.out_ready = 1'b1;
        bus1.in_data = '0; bus1.in_valid = 1'b0; bus1.out_ready = 1'b1;
        model_reset();
        last0 = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_data", longint'(bus0.out_data), 0);
        check("rst_out_valid", bus0.out_valid, 0);
        check("rst_busy", busy0, 0);
        check("rst_overrun", ovr0, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Latency of the first trigger, then the DC step settles to 1000.
        send(0, 1128, 30, 1'b1, 1000);
        send(0, 1128, 0, 1'b1, 1000);
        measure(0, cyc, bok);
        check("latency0", cyc, 18);
        check("busy0_mac", bok, 1);
        repeat (12) @(posedge clk);
        for (int i = 0; i < 30; i++) send(0, 1128, 30, 1'b1, 1000);

        for (int i = 0; i < 32; i++) send(0, 65535, 30, 1'b1, 32767);
        for (int i = 0; i < 32; i++) send(0, 0, 30, 1'b1, -128);

        // Backpressure: held output, dropped strobes, sticky overrun.
        @(posedge clk); #1 bus0.out_ready = 1'b0;
        send(0, 1128, 30, 1'b0, 0);
        send(0, 1128, 25, 1'b0, 0);
        #1;
        check("bp_valid", bus0.out_valid, 1);
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            bus0.in_data  = 16'd9999;
            bus0.in_valid = 1'b1;
            @(posedge clk); #1;
            bus0.in_valid = 1'b0;
            check("bp_overrun", ovr0, 1);
            repeat (198) @(posedge clk);
            #1;
            check("bp_hold_data", longint'(bus0.out_data), longint'(last0));
            check("bp_hold_valid", bus0.out_valid, 1);
        end
        @(posedge clk); #1 bus0.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("bp_released", bus0.out_valid, 0);
        check("bp_overrun_sticky", ovr0, 1);

        // Handshake and triggering accept in the same cycle (DECIM=1 instance).
        bus1.out_ready = 1'b0;
        send(1, 1128, 25, 1'b0, 0);
        #1;
        check("sim_pending", bus1.out_valid, 1);
        bus1.out_ready = 1'b1;
        bus1.in_data   = 16'd5128;
        bus1.in_valid  = 1'b1;
        for (int i = 15; i > 0; i--) h1[i] = h1[i-1];
        h1[0] = 5000;
        q1.push_back(fir_model(h1));
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        check("sim_busy", busy1, 1);
        check("sim_valid_low", bus1.out_valid, 0);
        check("sim_overrun", ovr1, 0);
        measure(1, cyc, bok);
        check("latency1", cyc, 18);
        check("busy1_mac", bok, 1);
        repeat (10) @(posedge clk);

        // Reset in the middle of a MAC run discards the partial result.
        send(0, 2128, 30, 1'b0, 0);
        send(0, 3128, 5, 1'b0, 0);
        void'(q0.pop_back());
        #3 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy0, 0);
        check("midrst_valid", bus0.out_valid, 0);
        check("midrst_overrun", ovr0, 0);
        check("midrst_data", longint'(bus0.out_data), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send(0, 2128, 30, 1'b0, 0);
        send(0, 3128, 30, 1'b0, 0);

        for (int j = 0; j < 60 && (q0.size() != 0 || q1.size() != 0); j++) @(posedge clk);
        #1;
        check("drain0", q0.size(), 0);
        check("drain1", q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
